// File: rtl/jk_drv_pkg.sv
//------------------------------------------------------------------------------
// Module   : jk_drv_pkg
// Brief    : Shared types, constants and per-bit JK excitation rule for the
//            JK excitation driver.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jk_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam int c_cnt_w = 4;

  // Returns {j,k} moving one latch from q to t; dc fills the don't-care slot.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    logic [1:0] jk;
    case ({q, t})
      2'b00:   jk = {1'b0, dc};
      2'b01:   jk = {1'b1, dc};
      2'b10:   jk = {dc, 1'b1};
      default: jk = {dc, 1'b0};
    endcase
    return jk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_excite_bit.sv
//------------------------------------------------------------------------------
// Module   : jk_excite_bit
// Brief    : Combinational single-latch J/K encoder; falls back to a
//            state-independent set/reset drive while the shadow is invalid.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jk_excite_bit
  import jk_drv_pkg::*;
#(
  parameter bit DC_FILL = 1'b0
) (
  input  logic i_q,
  input  logic i_t,
  input  logic i_vld,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  assign w_jk = i_vld ? jk_excite(i_q, i_t, DC_FILL) : {i_t, ~i_t};
  assign o_j  = w_jk[1];
  assign o_k  = w_jk[0];

endmodule

`default_nettype wire

// File: rtl/jk_excitation_driver.sv
//------------------------------------------------------------------------------
// Module   : jk_excitation_driver
// Brief    : Steers a WIDTH-bit JK latch bank to a requested value with a
//            one-cycle enable pulse and a settle window. Optional readback
//            of the bank through q_fb: JK_EXCITATION_DRIVER_READBACK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SETTLE  = 2,
  parameter int DC_FILL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             enable,
`ifdef JK_EXCITATION_DRIVER_READBACK_EN
  input  logic [WIDTH-1:0] q_fb,
`endif
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] shadow
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_target;
  logic [WIDTH-1:0]   r_shadow;
  logic               r_shadow_vld;
  logic               r_err;
  logic [WIDTH-1:0]   w_j;
  logic [WIDTH-1:0]   w_k;
  logic [WIDTH-1:0]   w_fb;
  logic               w_mismatch;

`ifdef JK_EXCITATION_DRIVER_READBACK_EN
  assign w_mismatch = (q_fb != r_target);
  assign w_fb       = q_fb;
`else
  assign w_mismatch = 1'b0;
  assign w_fb       = r_target;
`endif

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_excite_bit #(
        .DC_FILL (DC_FILL != 0)
      ) u_bit (
        .i_q   (r_shadow[gi]),
        .i_t   (r_target[gi]),
        .i_vld (r_shadow_vld),
        .o_j   (w_j[gi]),
        .o_k   (w_k[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_target     <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) r_target <= req_target;
        end
        ST_DRIVE: begin
          r_shadow     <= r_target;
          r_shadow_vld <= 1'b1;
          r_cnt        <= c_cnt_w'(SETTLE - 1);
        end
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // err is registered so it lines up with the CHECK cycle's done.
            r_err <= w_mismatch;
            if (w_mismatch) r_shadow <= w_fb;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    enable      = 1'b0;
    done        = 1'b0;
    j           = '0;
    k           = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        enable      = 1'b1;
        j           = w_j;
        k           = w_k;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign err    = r_err;
  assign shadow = r_shadow;

endmodule

`default_nettype wire
